// File: rtl/fe2de_inst_queue_pkg.sv
// Shared fetch/decode definitions: default PC width and the layout of a
// queued instruction entry {pc, ir, rv16, predict_taken}.
package fe2de_inst_queue_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned IR_W     = 32;

  // Entry field offsets, LSB first.
  localparam int unsigned PT_OFF   = 0;
  localparam int unsigned RV16_OFF = 1;
  localparam int unsigned IR_OFF   = 2;
  localparam int unsigned PC_OFF   = IR_OFF + IR_W;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  function automatic int unsigned entry_width(input int unsigned xlen);
    return xlen + PC_OFF;
  endfunction

endpackage

// File: rtl/fe2de_inst_queue_mem.sv
// Register-array storage for the instruction queue: one synchronous write
// port and one asynchronous read port, all entries cleared on reset.
module iq_mem #(
  parameter int unsigned WIDTH = 66,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fe2de_inst_queue.sv
// Instruction queue between fetch and decode with decode backpressure,
// wrong-path flush and optional empty-queue fall-through.
module fe2de_inst_queue
  import fe2de_inst_queue_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned BYPASS    = 1,
  parameter int unsigned AFULL_LVL = DEPTH - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fe_valid,
  input  logic [XLEN-1:0]        fe_pc,
  input  logic [31:0]            fe_ir,
  input  logic                   fe_rv16,
  input  logic                   fe_predict_taken,
  output logic                   fe_ready,
  output logic                   fe_afull,
  output logic                   de_valid,
  output logic [XLEN-1:0]        de_pc,
  output logic [31:0]            de_ir,
  output logic                   de_rv16,
  output logic                   de_predict_taken,
  input  logic                   de_ready,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = entry_width(XLEN);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt_q;
  logic          empty;
  logic          full;
  logic          bypass_take;
  logic          push;
  logic          pop;
  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);

  // Status flags come from the count register only, never from de_ready/flush.
  assign fe_ready = !full;
  assign fe_afull = (cnt_q >= AFULL_CNT);
  assign count    = cnt_q;

  assign bypass_take = (BYPASS != 0) && empty && fe_valid && de_ready;
  assign push        = fe_valid && fe_ready && !flush && !bypass_take;
  assign pop         = de_valid && de_ready && !empty;

  always_comb begin
    wdata                     = '0;
    wdata[PC_OFF +: XLEN]     = fe_pc;
    wdata[IR_OFF +: IR_W]     = fe_ir;
    wdata[RV16_OFF]           = fe_rv16;
    wdata[PT_OFF]             = fe_predict_taken;
  end

  iq_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_iq_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Head select must stay independent of flush: flush is derived from de_ir.
  always_comb begin
    de_valid         = 1'b0;
    de_pc            = rdata[PC_OFF +: XLEN];
    de_ir            = rdata[IR_OFF +: IR_W];
    de_rv16          = rdata[RV16_OFF];
    de_predict_taken = rdata[PT_OFF];
    if (!empty) begin
      de_valid = 1'b1;
    end else if (BYPASS != 0) begin
      de_valid         = fe_valid;
      de_pc            = fe_pc;
      de_ir            = fe_ir;
      de_rv16          = fe_rv16;
      de_predict_taken = fe_predict_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fe2de_inst_queue.sv
// Directed scoreboard bench for fe2de_inst_queue: a registered-only instance
// checked every cycle against a queue model, plus a bypass instance.
module tb_fe2de_inst_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fe_valid = 1'b0;
  logic [31:0] fe_pc = '0;
  logic [31:0] fe_ir = '0;
  logic        fe_rv16 = 1'b0;
  logic        fe_predict_taken = 1'b0;
  logic        de_ready = 1'b0;
  logic        flush = 1'b0;

  logic        fe_ready, fe_afull, de_valid, de_rv16, de_predict_taken;
  logic [31:0] de_pc, de_ir;
  logic [2:0]  count;

  logic        b_fe_ready, b_fe_afull, b_de_valid, b_de_rv16, b_de_predict_taken;
  logic [31:0] b_de_pc, b_de_ir;
  logic [2:0]  b_count;

  int total = 0;
  int bad   = 0;
  logic [65:0] sb [$];

  always #5 clk = ~clk;

  fe2de_inst_queue #(.XLEN(32), .DEPTH(4), .BYPASS(0), .AFULL_LVL(3)) dut (
    .clk(clk), .rst(rst), .fe_valid(fe_valid), .fe_pc(fe_pc), .fe_ir(fe_ir),
    .fe_rv16(fe_rv16), .fe_predict_taken(fe_predict_taken), .fe_ready(fe_ready),
    .fe_afull(fe_afull), .de_valid(de_valid), .de_pc(de_pc), .de_ir(de_ir),
    .de_rv16(de_rv16), .de_predict_taken(de_predict_taken), .de_ready(de_ready),
    .flush(flush), .count(count)
  );

  fe2de_inst_queue #(.XLEN(32), .DEPTH(4), .BYPASS(1), .AFULL_LVL(3)) dut_b (
    .clk(clk), .rst(rst), .fe_valid(fe_valid), .fe_pc(fe_pc), .fe_ir(fe_ir),
    .fe_rv16(fe_rv16), .fe_predict_taken(fe_predict_taken), .fe_ready(b_fe_ready),
    .fe_afull(b_fe_afull), .de_valid(b_de_valid), .de_pc(b_de_pc), .de_ir(b_de_ir),
    .de_rv16(b_de_rv16), .de_predict_taken(b_de_predict_taken), .de_ready(de_ready),
    .flush(flush), .count(b_count)
  );

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] ir,
                       input logic r16, input logic pt, input logic dr, input logic fl);
    fe_valid = fv;
    fe_pc = pc;
    fe_ir = ir;
    fe_rv16 = r16;
    fe_predict_taken = pt;
    de_ready = dr;
    flush = fl;
    #1;
  endtask

  task automatic check_main();
    int n;
    n = sb.size();
    chk("count", 80'(count), 80'(n));
    chk("fe_ready", 80'(fe_ready), 80'(n != 4));
    chk("fe_afull", 80'(fe_afull), 80'(n >= 3));
    chk("de_valid", 80'(de_valid), 80'(n != 0));
    if (n != 0) chk("head", 80'({de_pc, de_ir, de_rv16, de_predict_taken}), 80'(sb[0]));
  endtask

  // Scoreboard update for the registered-only instance, then advance one edge.
  task automatic adv();
    int n;
    logic [65:0] e;
    n = sb.size();
    e = {fe_pc, fe_ir, fe_rv16, fe_predict_taken};
    if (n != 0 && de_ready) void'(sb.pop_front());
    if (flush) sb.delete();
    else if (fe_valid && n != 4) sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] ir,
                      input logic r16, input logic pt, input logic dr, input logic fl);
    drive(fv, pc, ir, r16, pt, dr, fl);
    check_main();
    adv();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    logic        acc;

    // Reset values; bypass head follows fe_valid even in reset.
    rst = 1'b1;
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_count", 80'(count), 80'(0));
    chk("rst_fe_ready", 80'(fe_ready), 80'(1));
    chk("rst_fe_afull", 80'(fe_afull), 80'(0));
    chk("rst_de_valid", 80'(de_valid), 80'(0));
    chk("rst_b_de_valid1", 80'(b_de_valid), 80'(1));
    chk("rst_b_count", 80'(b_count), 80'(0));
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_b_de_valid0", 80'(b_de_valid), 80'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill with decode stalled, then an extra fetch that must be refused.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h110, 32'h13, 1'b0, 1'b0, 1'b0, 1'b0);

    // Sustained fetch and decode from full; fetch re-presents refused PCs.
    p = 32'h110;
    for (int i = 0; i < 6; i++) begin
      acc = (sb.size() != 4);
      step(1'b1, p, $urandom, 1'b0, 1'b0, 1'b1, 1'b0);
      if (acc) p = p + 32'd4;
    end
    for (int k = 0; k < 8 && sb.size() != 0; k++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Bypass: zero-latency issue when empty, storage used under stall.
    chk("byp_pre_count", 80'(b_count), 80'(0));
    drive(1'b1, 32'h200, 32'h00A00093, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("byp_valid", 80'(b_de_valid), 80'(1));
    chk("byp_head", 80'({b_de_pc, b_de_ir, b_de_rv16, b_de_predict_taken}),
        80'({32'h200, 32'h00A00093, 1'b1, 1'b1}));
    check_main();
    adv();
    chk("byp_count0", 80'(b_count), 80'(0));
    drive(1'b1, 32'h204, 32'h00B00113, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("byp_stall_valid", 80'(b_de_valid), 80'(1));
    chk("byp_stall_pc", 80'(b_de_pc), 80'(32'h204));
    check_main();
    adv();
    chk("byp_count1", 80'(b_count), 80'(1));
    chk("byp_afull", 80'(b_fe_afull), 80'(0));
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("byp_stored", 80'({b_de_valid, b_de_pc, b_de_ir, b_de_predict_taken}),
        80'({1'b1, 32'h204, 32'h00B00113, 1'b1}));
    check_main();
    adv();
    chk("byp_drained", 80'(b_count), 80'(0));
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Flush with decode ready: head issues, wrong-path fetch 0x300 dropped.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h280 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h300, 32'h13, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("flush_b_count", 80'(b_count), 80'(0));
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Flush while stalled discards the head too.
    for (int i = 0; i < 2; i++) step(1'b1, 32'h380 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Wrap-around with toggling flags.
    step(1'b1, 32'h400, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      step(1'b1, 32'h404 + 32'(4 * i), $urandom, 1'((i % 2) == 0), 1'(((i / 2) % 2) == 1), 1'b1, 1'b0);
    for (int k = 0; k < 8 && sb.size() != 0; k++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-push at count = 2.
    for (int i = 0; i < 2; i++) step(1'b1, 32'h500 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h508, 32'h00C00193, 1'b1, 1'b0, 1'b0, 1'b0);
    check_main();
    rst = 1'b1;
    #1;
    chk("arst_count", 80'(count), 80'(0));
    chk("arst_fe_ready", 80'(fe_ready), 80'(1));
    chk("arst_fe_afull", 80'(fe_afull), 80'(0));
    chk("arst_de_valid", 80'(de_valid), 80'(0));
    chk("arst_b_count", 80'(b_count), 80'(0));
    chk("arst_b_de_valid", 80'(b_de_valid), 80'(1));
    rst = 1'b0;
    sb.delete();
    #1;
    adv();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8 && sb.size() != 0; k++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
